// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side scheduler: FSM encoding,
// parity modes, frame length and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_ACT  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;
  localparam int   FRAME_BITS = 11;

  // Reduction XOR gives even parity; odd mode just flips it.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_sched_arb.sv
// Two-way round-robin arbiter; the last-grant register lives in the parent.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      // On contention, favour whichever requester was not served last.
      if (valid == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
      else                grant = valid;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Transmit scheduler: picks a requester, strobes the serializer, then
// tracks active/done with a start timeout and an optional inter-frame gap.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int GAP_CYCLES  = 1,
  parameter int ACT_TIMEOUT = 4
) (
  input  logic       baud_clk,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic       parity_odd,
  input  logic       err_clr,
  input  logic       tx_active,
  input  logic       tx_done,
  output logic       tx_send,
  output logic [7:0] tx_data,
  output logic       tx_parity,
  output logic       busy,
  output logic       grant_id,
  output logic       err_timeout
);

  localparam int CNT_MAX = (ACT_TIMEOUT > GAP_CYCLES) ? ACT_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ACT_LAST = CNT_W'(ACT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last_grant;
  logic [1:0]       grant;
  logic             accept;
  logic             err_set;
  logic [7:0]       acc_data;

  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .enable     (state == ST_IDLE),
    .grant      (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;
  assign acc_data   = grant[1] ? req1_data : req0_data;

  // Decoded from the state flop, so the strobe is exactly the SEND cycle
  // and drops with the asynchronous reset.
  assign tx_send = (state == ST_SEND);
  assign busy    = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_set   = 1'b0;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SEND;
      ST_SEND: begin
        state_nxt = ST_WAIT_ACT;
        cnt_nxt   = '0;
      end
      ST_WAIT_ACT: begin
        if (tx_active) begin
          state_nxt = ST_WAIT_DONE;
        end else if (cnt == ACT_LAST) begin
          // Serializer never started: drop the byte rather than retry.
          err_set   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_done) begin
          cnt_nxt   = '0;
          state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) state_nxt = ST_IDLE;
        else                 cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      last_grant  <= 1'b1;
      tx_data     <= 8'h00;
      tx_parity   <= 1'b0;
      grant_id    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        tx_data    <= acc_data;
        tx_parity  <= calc_parity(acc_data, parity_odd);
        grant_id   <= grant[1];
        last_grant <= grant[1];
      end
      if (err_set)      err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched: two instances (gap of 1 and 0 cycles),
// a serializer stand-in, and a timestamp-based reference model.
module tb_uart_tx_sched;

  localparam int AT  = 4;
  localparam int INF = 1 << 30;

  logic       baud_clk = 1'b0;
  logic       reset_n;
  logic [1:0] req0_valid, req1_valid, req0_ready, req1_ready;
  logic [1:0] parity_odd, err_clr, tx_active, tx_done;
  logic [1:0] tx_send, tx_parity, busy, grant_id, err_timeout;
  logic [7:0] req0_data [2];
  logic [7:0] req1_data [2];
  logic [7:0] tx_data   [2];

  always #5 baud_clk = ~baud_clk;

  uart_tx_sched #(.GAP_CYCLES(1), .ACT_TIMEOUT(AT)) u_dut_gap1 (
    .baud_clk (baud_clk), .reset_n (reset_n),
    .req0_valid (req0_valid[0]), .req0_data (req0_data[0]), .req0_ready (req0_ready[0]),
    .req1_valid (req1_valid[0]), .req1_data (req1_data[0]), .req1_ready (req1_ready[0]),
    .parity_odd (parity_odd[0]), .err_clr (err_clr[0]),
    .tx_active (tx_active[0]), .tx_done (tx_done[0]), .tx_send (tx_send[0]),
    .tx_data (tx_data[0]), .tx_parity (tx_parity[0]), .busy (busy[0]),
    .grant_id (grant_id[0]), .err_timeout (err_timeout[0])
  );

  uart_tx_sched #(.GAP_CYCLES(0), .ACT_TIMEOUT(AT)) u_dut_gap0 (
    .baud_clk (baud_clk), .reset_n (reset_n),
    .req0_valid (req0_valid[1]), .req0_data (req0_data[1]), .req0_ready (req0_ready[1]),
    .req1_valid (req1_valid[1]), .req1_data (req1_data[1]), .req1_ready (req1_ready[1]),
    .parity_odd (parity_odd[1]), .err_clr (err_clr[1]),
    .tx_active (tx_active[1]), .tx_done (tx_done[1]), .tx_send (tx_send[1]),
    .tx_data (tx_data[1]), .tx_parity (tx_parity[1]), .busy (busy[1]),
    .grant_id (grant_id[1]), .err_timeout (err_timeout[1])
  );

  int tests = 0, fails = 0;
  int cyc = 0;
  int cur_lane = 0;

  // Model: every event is a cycle stamp; the block is idle from free_at on.
  int         free_at [2], send_at [2], err_at [2];
  int         act_from [2], act_to [2], done_at [2];
  logic       last_g [2], e_par [2], e_gid [2], e_err [2];
  logic [7:0] e_data [2];
  logic       v0 [2], v1 [2], req1_en [2];
  logic [7:0] d0 [2], d1 [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s lane%0d cyc%0d: got %0h expected %0h", tag, cur_lane, cyc, got, exp);
    end
  endtask

  function automatic int gap_of(input int lane);
    return (lane == 0) ? 1 : 0;
  endfunction

  task automatic reset_model(input int lane);
    send_at[lane] = -1;  err_at[lane] = -1;
    act_from[lane] = -1; act_to[lane] = -1; done_at[lane] = -1;
    last_g[lane] = 1'b1; e_data[lane] = 8'h00;
    e_par[lane] = 1'b0;  e_gid[lane] = 1'b0; e_err[lane] = 1'b0;
  endtask

  task automatic step(input int lane);
    int ch;
    int k;
    @(negedge baud_clk);
    cyc++;
    tx_active[lane] = (cyc >= act_from[lane]) && (cyc <= act_to[lane]);
    tx_done[lane]   = (cyc == done_at[lane]) ||
                      (lane == 0 && cyc > done_at[lane] && cyc != send_at[lane] &&
                       $urandom_range(0, 15) == 0);
    if (!v0[lane] && (lane == 1 || $urandom_range(0, 2) == 0)) begin
      v0[lane] = 1'b1; d0[lane] = 8'($urandom);
    end
    if (req1_en[lane] && !v1[lane] && $urandom_range(0, 2) == 0) begin
      v1[lane] = 1'b1; d1[lane] = 8'($urandom);
    end
    req0_valid[lane] = v0[lane]; req0_data[lane] = d0[lane];
    req1_valid[lane] = v1[lane]; req1_data[lane] = d1[lane];
    parity_odd[lane] = 1'($urandom_range(0, 1));
    err_clr[lane]    = ($urandom_range(0, 7) == 0);
    #1;
    ch = -1;
    if (cyc >= free_at[lane]) begin
      if (v0[lane] && v1[lane]) ch = last_g[lane] ? 0 : 1;
      else if (v0[lane])        ch = 0;
      else if (v1[lane])        ch = 1;
    end
    check("ready0", req0_ready[lane], ch == 0);
    check("ready1", req1_ready[lane], ch == 1);
    check("tx_send", tx_send[lane], cyc == send_at[lane]);
    check("busy", busy[lane], cyc < free_at[lane]);
    check("tx_data", tx_data[lane], e_data[lane]);
    check("tx_parity", tx_parity[lane], e_par[lane]);
    check("grant_id", grant_id[lane], e_gid[lane]);
    check("err_timeout", err_timeout[lane], e_err[lane]);
    if (tx_done[lane]) check("send_with_done", tx_send[lane] & tx_done[lane], 0);
    // Serializer decides how long it takes to start; AT means it never does.
    if (cyc == send_at[lane]) begin
      k = $urandom_range(0, AT);
      if (k < AT) begin
        act_from[lane] = cyc + 1 + k;
        act_to[lane]   = act_from[lane] + 10;
        done_at[lane]  = act_to[lane] + 1;
        free_at[lane]  = done_at[lane] + 1 + gap_of(lane);
      end else begin
        free_at[lane] = cyc + 1 + AT;
        err_at[lane]  = cyc + 1 + AT;
      end
    end
    if (ch >= 0) begin
      send_at[lane] = cyc + 1;
      free_at[lane] = INF;
      last_g[lane]  = (ch == 1);
      e_gid[lane]   = (ch == 1);
      e_data[lane]  = (ch == 1) ? d1[lane] : d0[lane];
      e_par[lane]   = (^e_data[lane]) ^ parity_odd[lane];
      if (ch == 0) v0[lane] = 1'b0;
      else         v1[lane] = 1'b0;
    end
    if (cyc + 1 == err_at[lane]) e_err[lane] = 1'b1;
    else if (err_clr[lane])      e_err[lane] = 1'b0;
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    req0_valid = '0; req1_valid = '0; parity_odd = '0; err_clr = '0;
    tx_active = '0; tx_done = '0;
    for (int l = 0; l < 2; l++) begin
      req0_data[l] = 8'h00; req1_data[l] = 8'h00;
      reset_model(l);
      free_at[l] = 0;
      v0[l] = 1'b0; v1[l] = 1'b0; d0[l] = 8'h00; d1[l] = 8'h00;
      req1_en[l] = 1'b1;
    end
    repeat (2) @(negedge baud_clk);
    #1;
    for (int l = 0; l < 2; l++) begin
      cur_lane = l;
      check("rst_send", tx_send[l], 0);
      check("rst_busy", busy[l], 0);
      check("rst_data", tx_data[l], 8'h00);
      check("rst_parity", tx_parity[l], 0);
      check("rst_gid", grant_id[l], 0);
      check("rst_err", err_timeout[l], 0);
    end
    reset_n  = 1'b1;
    cur_lane = 0;
    v0[0] = 1'b1; d0[0] = 8'hA5;
    repeat (600) step(0);

    // Reset in WAIT_DONE right after requester 1 was served.
    n = 0;
    while (!(cyc > act_from[0] && cyc < done_at[0] && last_g[0] == 1'b1) && n < 400) begin
      step(0);
      n++;
    end
    check("reset_window_found", n < 400, 1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_send", tx_send[0], 0);
    check("midrst_busy", busy[0], 0);
    check("midrst_err", err_timeout[0], 0);
    check("midrst_data", tx_data[0], 8'h00);
    check("midrst_gid", grant_id[0], 0);
    reset_model(0);
    free_at[0] = cyc + 1;
    v0[0] = 1'b1; v1[0] = 1'b1;
    tx_active[0] = 1'b0; tx_done[0] = 1'b0;
    @(posedge baud_clk);
    #2 reset_n = 1'b1;
    step(0);
    check("post_reset_first_grant", req0_ready[0], 1);
    repeat (200) step(0);

    req0_valid[0] = 1'b0; req1_valid[0] = 1'b0;
    tx_active[0] = 1'b0;  tx_done[0] = 1'b0; err_clr[0] = 1'b0;
    cur_lane   = 1;
    req1_en[1] = 1'b0;
    repeat (400) step(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
